// File: rtl/miner_sweep_ctrl_pkg.sv
// Shared constants and helpers for the nonce-sweep miner controller.
// Byte-order helpers follow the Bitcoin serialization of nonce and digest.
package miner_sweep_ctrl_pkg;

    localparam int LEN_HDR    = 640;
    localparam int LEN_DIGEST = 256;

    localparam logic [LEN_DIGEST-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MID    = 3'd1;
    localparam logic [2:0] ST_BLK2   = 3'd2;
    localparam logic [2:0] ST_FINAL  = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_REPORT = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_DRAIN  = 3'd7;

    // Which block/chaining pair is presented to the core; survives into DRAIN.
    localparam logic [1:0] REQ_NONE = 2'd0;
    localparam logic [1:0] REQ_B1   = 2'd1;
    localparam logic [1:0] REQ_B2   = 2'd2;
    localparam logic [1:0] REQ_BF   = 2'd3;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [255:0] bswap256(input logic [255:0] x);
        logic [255:0] y;
        for (int i = 0; i < 32; i++) y[8*i +: 8] = x[255-8*i -: 8];
        return y;
    endfunction

endpackage

// File: rtl/miner_sweep_ctrl_if.sv
// Job control, compression-core handshake and hit-report signals of the miner controller.
// slave = controller side, master = host/core side.
interface miner_sweep_ctrl_if
    import miner_sweep_ctrl_pkg::*;
#(
    parameter int NONCE_W = 32
) ();

    logic                  start;
    logic                  abort;
    logic [LEN_HDR-1:0]    header;
    logic [NONCE_W-1:0]    nonce_start;
    logic [NONCE_W-1:0]    nonce_end;
    logic                  sha_start;
    logic [511:0]          sha_block;
    logic [LEN_DIGEST-1:0] sha_h_in;
    logic                  sha_done;
    logic [LEN_DIGEST-1:0] sha_h_out;
    logic                  busy;
    logic                  found_valid;
    logic                  found_ready;
    logic [NONCE_W-1:0]    found_nonce;
    logic [LEN_DIGEST-1:0] found_hash;
    logic                  exhausted;
    logic [31:0]           hash_count;

    modport slave (
        input  start, abort, header, nonce_start, nonce_end, sha_done, sha_h_out, found_ready,
        output sha_start, sha_block, sha_h_in, busy, found_valid, found_nonce, found_hash,
               exhausted, hash_count
    );

    modport master (
        output start, abort, header, nonce_start, nonce_end, sha_done, sha_h_out, found_ready,
        input  sha_start, sha_block, sha_h_in, busy, found_valid, found_nonce, found_hash,
               exhausted, hash_count
    );

endinterface

// File: rtl/miner_sweep_ctrl_block_pack.sv
// Padded second header block (nonce inserted little-endian) and padded digest block
// for the outer SHA-256 pass.
module miner_sweep_ctrl_block_pack
    import miner_sweep_ctrl_pkg::*;
#(
    parameter int NONCE_W = 32
) (
    input  logic [95:0]           i_hdr_tail,
    input  logic [NONCE_W-1:0]    i_nonce,
    input  logic [LEN_DIGEST-1:0] i_digest,
    output logic [511:0]          o_blk2,
    output logic [511:0]          o_blkf
);

    logic [31:0] w_nonce32;

    assign w_nonce32 = 32'(i_nonce);
    assign o_blk2    = {i_hdr_tail, bswap32(w_nonce32), 1'b1, 319'b0, 64'(LEN_HDR)};
    assign o_blkf    = {i_digest, 1'b1, 191'b0, 64'(LEN_DIGEST)};

endmodule

// File: rtl/miner_sweep_ctrl.sv
// Nonce-sweeping SHA-256d controller driving an external compression core.
// First-block midstate is cached per job; each nonce then costs block 2 plus the final hash.
module miner_sweep_ctrl
    import miner_sweep_ctrl_pkg::*;
#(
    parameter int NONCE_W      = 32,
    parameter int ZERO_BITS    = 19,
    parameter int CHECK_LE     = 1,
    parameter int STOP_ON_FIND = 1
) (
    input logic               i_clk,
    input logic               i_rst,
    miner_sweep_ctrl_if.slave bus
);

    // Top ZERO_BITS bits set; ZERO_BITS==0 yields an all-zero mask, so every nonce hits.
    localparam logic [LEN_DIGEST-1:0] HIT_MASK = ~({LEN_DIGEST{1'b1}} >> ZERO_BITS);

    logic [2:0]            r_state;
    logic [1:0]            r_req;
    logic [LEN_HDR-1:32]   r_hdr;
    logic [NONCE_W-1:0]    r_nonce;
    logic [NONCE_W-1:0]    r_end;
    logic [NONCE_W-1:0]    r_found_nonce;
    logic [LEN_DIGEST-1:0] r_mid;
    logic [LEN_DIGEST-1:0] r_digest1;
    logic [LEN_DIGEST-1:0] r_hash;
    logic [LEN_DIGEST-1:0] r_found_hash;
    logic                  r_sha_start;
    logic                  r_found_valid;
    logic                  r_exhausted;
    logic [31:0]           r_hash_count;

    logic [511:0]          w_blk2;
    logic [511:0]          w_blkf;
    logic [511:0]          w_sha_block;
    logic [LEN_DIGEST-1:0] w_sha_h_in;
    logic [LEN_DIGEST-1:0] w_chk;
    logic                  w_hit;
    logic                  w_last;
    logic                  w_unused_hdr;

    miner_sweep_ctrl_block_pack #(.NONCE_W(NONCE_W)) u_pack (
        .i_hdr_tail (r_hdr[127:32]),
        .i_nonce    (r_nonce),
        .i_digest   (r_digest1),
        .o_blk2     (w_blk2),
        .o_blkf     (w_blkf)
    );

    // The serialized nonce field is replaced by the sweep counter.
    assign w_unused_hdr = ^bus.header[31:0];

    assign w_chk  = (CHECK_LE != 0) ? bswap256(r_hash) : r_hash;
    assign w_hit  = (w_chk & HIT_MASK) == '0;
    assign w_last = (r_nonce == r_end);

    always_comb begin
        w_sha_block = '0;
        w_sha_h_in  = '0;
        case (r_req)
            REQ_B1: begin
                w_sha_block = r_hdr[LEN_HDR-1:128];
                w_sha_h_in  = SHA256_IV;
            end
            REQ_B2: begin
                w_sha_block = w_blk2;
                w_sha_h_in  = r_mid;
            end
            REQ_BF: begin
                w_sha_block = w_blkf;
                w_sha_h_in  = SHA256_IV;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_req         <= REQ_NONE;
            r_hdr         <= '0;
            r_nonce       <= '0;
            r_end         <= '0;
            r_found_nonce <= '0;
            r_mid         <= '0;
            r_digest1     <= '0;
            r_hash        <= '0;
            r_found_hash  <= '0;
            r_sha_start   <= 1'b0;
            r_found_valid <= 1'b0;
            r_exhausted   <= 1'b0;
            r_hash_count  <= '0;
        end else begin
            r_sha_start <= 1'b0;
            r_exhausted <= 1'b0;
            if (r_sha_start) r_hash_count <= r_hash_count + 32'd1;

            case (r_state)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_hdr        <= bus.header[LEN_HDR-1:32];
                        r_nonce      <= bus.nonce_start;
                        r_end        <= bus.nonce_end;
                        r_hash_count <= '0;
                        r_req        <= REQ_B1;
                        r_sha_start  <= 1'b1;
                        r_state      <= ST_MID;
                    end
                end
                ST_MID, ST_BLK2, ST_FINAL: begin
                    // A done coinciding with abort leaves nothing outstanding: skip DRAIN.
                    if (bus.abort) begin
                        if (bus.sha_done) begin
                            r_req   <= REQ_NONE;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (bus.sha_done) begin
                        if (r_state == ST_MID) begin
                            r_mid       <= bus.sha_h_out;
                            r_req       <= REQ_B2;
                            r_sha_start <= 1'b1;
                            r_state     <= ST_BLK2;
                        end else if (r_state == ST_BLK2) begin
                            r_digest1   <= bus.sha_h_out;
                            r_req       <= REQ_BF;
                            r_sha_start <= 1'b1;
                            r_state     <= ST_FINAL;
                        end else begin
                            r_hash  <= bus.sha_h_out;
                            r_state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (bus.abort) begin
                        r_req   <= REQ_NONE;
                        r_state <= ST_IDLE;
                    end else if (w_hit) begin
                        r_found_valid <= 1'b1;
                        r_found_nonce <= r_nonce;
                        r_found_hash  <= r_hash;
                        r_state       <= ST_REPORT;
                    end else if (w_last) begin
                        r_exhausted <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_nonce     <= r_nonce + NONCE_W'(1);
                        r_req       <= REQ_B2;
                        r_sha_start <= 1'b1;
                        r_state     <= ST_BLK2;
                    end
                end
                ST_REPORT: begin
                    if (bus.abort) begin
                        r_found_valid <= 1'b0;
                        r_req         <= REQ_NONE;
                        r_state       <= ST_IDLE;
                    end else if (bus.found_ready) begin
                        r_found_valid <= 1'b0;
                        if (STOP_ON_FIND != 0 || w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_nonce     <= r_nonce + NONCE_W'(1);
                            r_req       <= REQ_B2;
                            r_sha_start <= 1'b1;
                            r_state     <= ST_BLK2;
                        end
                    end
                end
                ST_DONE: begin
                    r_req   <= REQ_NONE;
                    r_state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (bus.sha_done) begin
                        r_req   <= REQ_NONE;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_req   <= REQ_NONE;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sha_start   = r_sha_start;
    assign bus.sha_block   = w_sha_block;
    assign bus.sha_h_in    = w_sha_h_in;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.found_valid = r_found_valid;
    assign bus.found_nonce = r_found_nonce;
    assign bus.found_hash  = r_found_hash;
    assign bus.exhausted   = r_exhausted;
    assign bus.hash_count  = r_hash_count;

endmodule

// File: tb/tb_miner_sweep_ctrl.sv
// Directed bench: two controller instances (stop-on-find/32 zero bits, and resume/0 zero bits)
// each driven by a behavioural SHA-256 core with 64..72 cycle latency.
module tb_miner_sweep_ctrl;
    import miner_sweep_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    miner_sweep_ctrl_if #(.NONCE_W(32)) ifa ();
    miner_sweep_ctrl_if #(.NONCE_W(32)) ifb ();

    miner_sweep_ctrl #(.NONCE_W(32), .ZERO_BITS(32), .CHECK_LE(1), .STOP_ON_FIND(1)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifa)
    );

    miner_sweep_ctrl #(.NONCE_W(32), .ZERO_BITS(0), .CHECK_LE(1), .STOP_ON_FIND(0)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifb)
    );

    localparam logic [639:0] GENESIS = {
        32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c
    };
    localparam logic [255:0] GEN_HASH =
        256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Behavioural cores and event monitors.
    int a_cnt = 0, b_cnt = 0;
    logic [255:0] a_res, b_res;
    int a_exh = 0, a_ss = 0, a_fv = 0, b_exh = 0, b_ss = 0;

    always @(posedge clk) begin
        if (rst) begin
            a_cnt <= 0;
            ifa.sha_done <= 1'b0;
            ifa.sha_h_out <= '0;
        end else begin
            ifa.sha_done <= 1'b0;
            if (ifa.sha_start) begin
                a_res <= sha_compress(ifa.sha_h_in, ifa.sha_block);
                a_cnt <= 64 + int'($urandom_range(0, 8));
            end else if (a_cnt == 1) begin
                ifa.sha_done  <= 1'b1;
                ifa.sha_h_out <= a_res;
                a_cnt <= 0;
            end else if (a_cnt > 1) a_cnt <= a_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            b_cnt <= 0;
            ifb.sha_done <= 1'b0;
            ifb.sha_h_out <= '0;
        end else begin
            ifb.sha_done <= 1'b0;
            if (ifb.sha_start) begin
                b_res <= sha_compress(ifb.sha_h_in, ifb.sha_block);
                b_cnt <= 64 + int'($urandom_range(0, 8));
            end else if (b_cnt == 1) begin
                ifb.sha_done  <= 1'b1;
                ifb.sha_h_out <= b_res;
                b_cnt <= 0;
            end else if (b_cnt > 1) b_cnt <= b_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (ifa.exhausted === 1'b1)   a_exh <= a_exh + 1;
        if (ifa.sha_start === 1'b1)   a_ss  <= a_ss + 1;
        if (ifa.found_valid === 1'b1) a_fv  <= a_fv + 1;
        if (ifb.exhausted === 1'b1)   b_exh <= b_exh + 1;
        if (ifb.sha_start === 1'b1)   b_ss  <= b_ss + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_a(input logic [31:0] s, input logic [31:0] e);
        @(negedge clk);
        ifa.header = GENESIS; ifa.nonce_start = s; ifa.nonce_end = e; ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, snap_ss, snap_fv, snap_exh, snap_bss;
        logic stable;
        logic [31:0]  n0;
        logic [255:0] h0;
        logic [31:0]  expn [4];
        expn = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};

        ifa.start = 0; ifa.abort = 0; ifa.header = '0; ifa.nonce_start = 0; ifa.nonce_end = 0; ifa.found_ready = 0;
        ifb.start = 0; ifb.abort = 0; ifb.header = '0; ifb.nonce_start = 0; ifb.nonce_end = 0; ifb.found_ready = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", ifa.busy, 0);
        chk("rst_flags", {ifa.sha_start, ifa.found_valid, ifa.exhausted}, 0);
        chk("rst_hash_count", ifa.hash_count, 0);
        chk("rst_sha_block", ifa.sha_block, 0);
        @(negedge clk); rst = 1'b0;

        // Genesis range with one hit at 0x7C2BAC1D.
        start_a(32'h7C2BAC1B, 32'h7C2BAC1F);
        chk("t1_busy_after_start", ifa.busy, 1);
        n = 0;
        while (ifa.found_valid !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        chk("t1_found_valid", ifa.found_valid, 1);
        chk("t1_found_nonce", ifa.found_nonce, 32'h7C2BAC1D);
        chk("t1_found_hash", ifa.found_hash, GEN_HASH);
        chk("t1_hash_count", ifa.hash_count, 7);
        ifa.found_ready = 1'b1;
        @(negedge clk); ifa.found_ready = 1'b0;
        chk("t1_valid_dropped", ifa.found_valid, 0);
        chk("t1_done_busy", ifa.busy, 1);
        chk("t1_no_exhausted", ifa.exhausted, 0);
        @(negedge clk);
        chk("t1_idle_busy", ifa.busy, 0);
        chk("t1_exh_count", a_exh, 0);

        // Range 0..9 without a hit, with a start pulse while busy.
        snap_fv = a_fv; snap_exh = a_exh;
        start_a(32'd0, 32'd9);
        n = 0;
        while (ifa.hash_count !== 32'd3 && n < 400) begin @(negedge clk); n++; end
        ifa.nonce_start = 32'd5; ifa.start = 1'b1;
        @(negedge clk); ifa.start = 1'b0;
        n = 0;
        while (ifa.exhausted !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        chk("t2_exhausted", ifa.exhausted, 1);
        chk("t2_hash_count", ifa.hash_count, 21);
        chk("t2_busy_in_done", ifa.busy, 1);
        chk("t2_no_found", a_fv - snap_fv, 0);
        @(negedge clk);
        chk("t2_exh_pulse_end", ifa.exhausted, 0);
        chk("t2_idle_busy", ifa.busy, 0);
        chk("t2_exh_count", a_exh - snap_exh, 1);

        // start together with abort in IDLE.
        snap_ss = a_ss;
        @(negedge clk); ifa.start = 1'b1; ifa.abort = 1'b1;
        @(negedge clk); ifa.start = 1'b0; ifa.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_busy", ifa.busy, 0);
        chk("t6_hash_count", ifa.hash_count, 21);
        chk("t6_sha_starts", a_ss - snap_ss, 0);

        // abort during BLK2.
        snap_fv = a_fv; snap_exh = a_exh;
        start_a(32'd0, 32'd9);
        n = 0;
        while (ifa.hash_count !== 32'd2 && n < 400) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        ifa.abort = 1'b1;
        snap_ss = a_ss;
        n = 0;
        while (ifa.sha_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("t4_busy_at_done", ifa.busy, 1);
        @(negedge clk);
        chk("t4_busy_after_done", ifa.busy, 0);
        ifa.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_no_new_start", a_ss - snap_ss, 0);
        chk("t4_hash_count", ifa.hash_count, 2);
        chk("t4_no_found_exh", {a_fv - snap_fv, a_exh - snap_exh}, 0);

        // Asynchronous reset during FINAL, then a full job.
        start_a(32'd0, 32'd9);
        n = 0;
        while (ifa.hash_count !== 32'd3 && n < 400) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", ifa.busy, 0);
        chk("t5_hash_count", ifa.hash_count, 0);
        chk("t5_sha_io", {ifa.sha_block, ifa.sha_h_in}, 0);
        chk("t5_found", {ifa.found_valid, ifa.exhausted, ifa.sha_start, ifa.found_nonce}, 0);
        chk("t5_found_hash", ifa.found_hash, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        start_a(32'h7C2BAC1B, 32'h7C2BAC1F);
        n = 0;
        while (ifa.found_valid !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        chk("t5_rerun_nonce", ifa.found_nonce, 32'h7C2BAC1D);
        chk("t5_rerun_hash", ifa.found_hash, GEN_HASH);
        chk("t5_rerun_count", ifa.hash_count, 7);
        ifa.found_ready = 1'b1;
        @(negedge clk); ifa.found_ready = 1'b0;

        // Resume-after-hit instance, wrapping range with a stalled consumer.
        snap_bss = b_ss;
        @(negedge clk);
        ifb.header = GENESIS; ifb.nonce_start = 32'hFFFFFFFE; ifb.nonce_end = 32'h1; ifb.start = 1'b1;
        @(negedge clk); ifb.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (ifb.found_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
            chk("t3_found_valid", ifb.found_valid, 1);
            chk("t3_found_nonce", ifb.found_nonce, expn[k]);
            chk("t3_hash_count", ifb.hash_count, 32'(3 + 2 * k));
            n0 = ifb.found_nonce; h0 = ifb.found_hash; stable = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (ifb.found_valid !== 1'b1 || ifb.found_nonce !== n0 || ifb.found_hash !== h0) stable = 1'b0;
            end
            chk("t3_stable_while_stalled", stable, 1);
            ifb.found_ready = 1'b1;
            @(negedge clk); ifb.found_ready = 1'b0;
            chk("t3_accepted", ifb.found_valid, 0);
        end
        n = 0;
        while (ifb.busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        chk("t3_idle", ifb.busy, 0);
        chk("t3_no_exhausted", b_exh, 0);
        chk("t3_sha_starts", b_ss - snap_bss, 9);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
